// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-RAM write/status bundle for program_loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  iStart;
    logic                  iByteValid;
    logic [7:0]            iByte;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [27:0]           oInstruction;
    logic                  oCpuReset;
    logic                  oDone;
    logic                  oError;
    logic [1:0]            oErrorCode;

    modport master (
        output iStart, iByteValid, iByte,
        input  oWriteEnable, oWriteAddress, oInstruction,
        input  oCpuReset, oDone, oError, oErrorCode
    );

    modport slave (
        input  iStart, iByteValid, iByte,
        output oWriteEnable, oWriteAddress, oInstruction,
        output oCpuReset, oDone, oError, oErrorCode
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte stream -> 28-bit instruction-RAM writes, core held in reset until a good checksum.
// Write strobe 1 cycle after each 4th data byte, status 1 cycle after CSUM; no backpressure, a byte per cycle accepted.
module program_loader #(
    parameter int          ADDR_WIDTH     = 16,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic            Clock,
    input  logic            Reset,
    program_loader_if.slave bus
);
    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_HDR,
        GET_COUNT,
        GET_DATA,
        GET_CSUM,
        DONE,
        ERROR
    } state_t;

    state_t                state,        stateNext;
    logic [7:0]            frameCount,   frameCountNext;
    logic [7:0]            instrCount,   instrCountNext;
    logic [7:0]            checksum,     checksumNext;
    logic [1:0]            byteIndex,    byteIndexNext;
    logic [23:0]           lowBytes,     lowBytesNext;
    logic [TW-1:0]         idleCount,    idleCountNext;
    logic                  writeEnable,  writeEnableNext;
    logic [ADDR_WIDTH-1:0] writeAddress, writeAddressNext;
    logic [27:0]           instruction,  instructionNext;
    logic [1:0]            errorCode,    errorCodeNext;
    logic                  inFrame;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= WAIT_HDR;
            frameCount   <= '0;
            instrCount   <= '0;
            checksum     <= '0;
            byteIndex    <= '0;
            lowBytes     <= '0;
            idleCount    <= '0;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            instruction  <= '0;
            errorCode    <= '0;
        end else begin
            state        <= stateNext;
            frameCount   <= frameCountNext;
            instrCount   <= instrCountNext;
            checksum     <= checksumNext;
            byteIndex    <= byteIndexNext;
            lowBytes     <= lowBytesNext;
            idleCount    <= idleCountNext;
            writeEnable  <= writeEnableNext;
            writeAddress <= writeAddressNext;
            instruction  <= instructionNext;
            errorCode    <= errorCodeNext;
        end
    end

    always_comb begin
        stateNext        = state;
        frameCountNext   = frameCount;
        instrCountNext   = instrCount;
        checksumNext     = checksum;
        byteIndexNext    = byteIndex;
        lowBytesNext     = lowBytes;
        idleCountNext    = idleCount;
        writeEnableNext  = 1'b0;
        writeAddressNext = writeAddress;
        instructionNext  = instruction;
        errorCodeNext    = errorCode;
        inFrame          = (state == GET_COUNT) || (state == GET_DATA) || (state == GET_CSUM);

        // Address advances in the cycle after the strobe so the RAM sees a stable address.
        if (writeEnable) begin
            writeAddressNext = writeAddress + ADDR_WIDTH'(1);
        end

        if (inFrame) begin
            if (bus.iByteValid) begin
                idleCountNext = '0;
            end else if (idleCount == TIMEOUT_LAST) begin
                stateNext     = ERROR;
                errorCodeNext = 2'd3;
            end else begin
                idleCountNext = idleCount + TW'(1);
            end
        end

        case (state)
            WAIT_HDR: begin
                if (bus.iByteValid && (bus.iByte == HEADER)) begin
                    stateNext      = GET_COUNT;
                    checksumNext   = '0;
                    byteIndexNext  = '0;
                    instrCountNext = '0;
                    idleCountNext  = '0;
                end
            end
            GET_COUNT: begin
                if (bus.iByteValid) begin
                    if (bus.iByte == 8'd0) begin
                        stateNext     = ERROR;
                        errorCodeNext = 2'd1;
                    end else begin
                        frameCountNext   = bus.iByte;
                        writeAddressNext = '0;
                        stateNext        = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (bus.iByteValid) begin
                    checksumNext = checksum ^ bus.iByte;
                    if (byteIndex == 2'd3) begin
                        // Upper nibble of the last byte is padding beyond the 28-bit word.
                        writeEnableNext = 1'b1;
                        instructionNext = {bus.iByte[3:0], lowBytes};
                        byteIndexNext   = '0;
                        instrCountNext  = instrCount + 8'd1;
                        if (instrCount == frameCount - 8'd1) begin
                            stateNext = GET_CSUM;
                        end
                    end else begin
                        lowBytesNext  = {bus.iByte, lowBytes[23:8]};
                        byteIndexNext = byteIndex + 2'd1;
                    end
                end
            end
            GET_CSUM: begin
                if (bus.iByteValid) begin
                    if (bus.iByte == checksum) begin
                        stateNext = DONE;
                    end else begin
                        stateNext     = ERROR;
                        errorCodeNext = 2'd2;
                    end
                end
            end
            DONE, ERROR: begin
                if (bus.iStart) begin
                    stateNext      = WAIT_HDR;
                    errorCodeNext  = '0;
                    checksumNext   = '0;
                    byteIndexNext  = '0;
                    instrCountNext = '0;
                    idleCountNext  = '0;
                    frameCountNext = '0;
                end
            end
            default: stateNext = WAIT_HDR;
        endcase
    end

    assign bus.oWriteEnable  = writeEnable;
    assign bus.oWriteAddress = writeAddress;
    assign bus.oInstruction  = instruction;
    assign bus.oCpuReset     = (state != DONE);
    assign bus.oDone         = (state == DONE);
    assign bus.oError        = (state == ERROR);
    assign bus.oErrorCode    = errorCode;
endmodule

// File: tb/tb_program_loader.sv
// Directed frames into program_loader; expected RAM writes are queued and checked by a negedge monitor.
module tb_program_loader;
    logic Clock;
    logic Reset;
    int   cyc;
    int   checks;
    int   errors;
    int   nextAddr;

    typedef struct {
        logic [15:0] addr;
        logic [27:0] data;
        int          cyc;
    } wr_t;

    wr_t expQ[$];
    wr_t mon;

    program_loader_if #(.ADDR_WIDTH(16)) bus ();

    program_loader #(
        .ADDR_WIDTH    (16),
        .HEADER        (8'hA5),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.iByteValid = 1'b1;
        bus.iByte      = b;
        @(posedge Clock);
        #1;
        bus.iByteValid = 1'b0;
        bus.iByte      = 8'h00;
    endtask

    task automatic sendInstr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [27:0] expData, input int gap);
        sendByte(b0); idle(gap);
        sendByte(b1); idle(gap);
        sendByte(b2); idle(gap);
        sendByte(b3);
        expQ.push_back('{addr: 16'(nextAddr), data: expData, cyc: cyc});
        nextAddr++;
        idle(gap);
    endtask

    task automatic pulseStart();
        bus.iStart = 1'b1;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input logic done, input logic err,
                               input logic [1:0] code, input logic cpuRst);
        check({tag, "_done"},   32'(bus.oDone),      32'(done));
        check({tag, "_error"},  32'(bus.oError),     32'(err));
        check({tag, "_code"},   32'(bus.oErrorCode), 32'(code));
        check({tag, "_cpurst"}, 32'(bus.oCpuReset),  32'(cpuRst));
    endtask

    task automatic checkDrained(input string tag);
        idle(2);
        check({tag, "_pending_writes"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        nextAddr       = 0;
        Reset          = 1'b1;
        bus.iStart     = 1'b0;
        bus.iByteValid = 1'b0;
        bus.iByte      = 8'h00;

        fork
            forever begin
                @(negedge Clock);
                if (bus.oWriteEnable) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write addr=%0h data=%0h cycle=%0d",
                                 bus.oWriteAddress, bus.oInstruction, cyc);
                    end else begin
                        mon = expQ.pop_front();
                        if (bus.oWriteAddress !== mon.addr || bus.oInstruction !== mon.data ||
                            cyc != mon.cyc) begin
                            errors++;
                            $display("FAIL write actual addr=%0h data=%0h cycle=%0d expected addr=%0h data=%0h cycle=%0d",
                                     bus.oWriteAddress, bus.oInstruction, cyc, mon.addr, mon.data, mon.cyc);
                        end
                    end
                end
            end
        join_none

        idle(3);
        check("rst_we",   32'(bus.oWriteEnable),  32'd0);
        check("rst_addr", 32'(bus.oWriteAddress), 32'd0);
        check("rst_instr", 32'(bus.oInstruction), 32'd0);
        checkStatus("rst", 1'b0, 1'b0, 2'd0, 1'b1);
        Reset = 1'b0;
        idle(2);

        // 1: single instruction, good checksum (78^56^34^F2 = E8)
        nextAddr = 0;
        sendByte(8'hA5); idle(1);
        sendByte(8'h01); idle(1);
        sendInstr(8'h78, 8'h56, 8'h34, 8'hF2, 28'h2345678, 1);
        sendByte(8'hE8);
        checkStatus("t1", 1'b1, 1'b0, 2'd0, 1'b0);
        sendByte(8'hA5);
        checkStatus("t1_ignore", 1'b1, 1'b0, 2'd0, 1'b0);
        checkDrained("t1");
        pulseStart();
        checkStatus("t1_rearm", 1'b0, 1'b0, 2'd0, 1'b1);

        // 2: three instructions, checksum should be 30, send 31
        nextAddr = 0;
        sendByte(8'hA5); idle(2);
        sendByte(8'h03); idle(2);
        sendInstr(8'h11, 8'h22, 8'h33, 8'h44, 28'h4332211, 2);
        sendInstr(8'h01, 8'h02, 8'h03, 8'hF4, 28'h4030201, 2);
        sendInstr(8'hAA, 8'hBB, 8'hCC, 8'h5D, 28'hDCCBBAA, 2);
        sendByte(8'h31);
        checkStatus("t2", 1'b0, 1'b1, 2'd2, 1'b1);
        checkDrained("t2");
        pulseStart();
        checkStatus("t2_rearm", 1'b0, 1'b0, 2'd0, 1'b1);

        // 3: junk before header, then zero count
        sendByte(8'h00); idle(1);
        sendByte(8'hFF); idle(1);
        check("t3_junk_ignored", 32'(bus.oError), 32'd0);
        sendByte(8'hA5); idle(1);
        sendByte(8'h00);
        checkStatus("t3", 1'b0, 1'b1, 2'd1, 1'b1);
        checkDrained("t3");
        pulseStart();
        checkStatus("t3_rearm", 1'b0, 1'b0, 2'd0, 1'b1);

        // 4: stall after three data bytes; error exactly after 1000 idle cycles
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h10); idle(1);
        sendByte(8'h20); idle(1);
        sendByte(8'h30);
        idle(999);
        check("t4_no_early_timeout", 32'(bus.oError), 32'd0);
        idle(1);
        checkStatus("t4", 1'b0, 1'b1, 2'd3, 1'b1);
        checkDrained("t4");
        pulseStart();
        checkStatus("t4_rearm", 1'b0, 1'b0, 2'd0, 1'b1);

        // 5: back-to-back bytes, COUNT=2, checksum 00
        nextAddr = 0;
        sendByte(8'hA5);
        sendByte(8'h02);
        sendInstr(8'h01, 8'h23, 8'h45, 8'h67, 28'h7452301, 0);
        sendInstr(8'h89, 8'hAB, 8'hCD, 8'hEF, 28'hFCDAB89, 0);
        sendByte(8'h00);
        checkStatus("t5", 1'b1, 1'b0, 2'd0, 1'b0);
        checkDrained("t5");
        pulseStart();

        // 6: reset mid-frame, then a fresh COUNT=1 frame (checksum 40)
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'hDE);
        sendByte(8'hAD);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        checkStatus("t6_reset", 1'b0, 1'b0, 2'd0, 1'b1);
        check("t6_reset_addr", 32'(bus.oWriteAddress), 32'd0);
        nextAddr = 0;
        sendByte(8'hA5);
        sendByte(8'h01);
        sendInstr(8'h10, 8'h20, 8'h30, 8'h40, 28'h0302010, 0);
        sendByte(8'h40);
        checkStatus("t6", 1'b1, 1'b0, 2'd0, 1'b0);
        checkDrained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
